riscv_mem_arbiter: RTL and testbench

- Round-robin burst arbiter that shares one synchronous memory port (ROM/RAM class, fixed read latency) between the instruction-cache and data-cache refill engines.
- Grants one requester for a whole cache-line burst and generates wrapping beat addresses.
- Tracks in-flight reads through a latency pipeline and returns data and last-beat flags to the owner.
- Sits between the cache miss handlers and the memory-side bus decode.

---
 rtl/riscv_mem_arbiter_if.sv | 36 +++
 rtl/riscv_mem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_riscv_mem_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_mem_arbiter_if.sv
// Signal bundle between the i/d cache refill engines, the burst arbiter and the memory port.
interface riscv_mem_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [63:0] i_rdata;
    logic        i_rlast;
    logic        d_req;
    logic [3:0]  d_wen;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_rlast;
    logic [31:0] mem_addr;
    logic        mem_ren;
    logic [3:0]  mem_wen;
    logic [31:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        busy;

    // Caches and memory model drive requests and read data; they observe everything else.
    modport master (
        output i_req, i_addr, d_req, d_wen, d_addr, d_wdata, mem_rdata,
        input  i_gnt, i_rvalid, i_rdata, i_rlast, d_gnt, d_rvalid, d_rdata, d_rlast,
               mem_addr, mem_ren, mem_wen, mem_wdata, busy
    );

    modport slave (
        input  i_req, i_addr, d_req, d_wen, d_addr, d_wdata, mem_rdata,
        output i_gnt, i_rvalid, i_rdata, i_rlast, d_gnt, d_rvalid, d_rdata, d_rlast,
               mem_addr, mem_ren, mem_wen, mem_wdata, busy
    );
endinterface

// File: rtl/riscv_mem_arbiter.sv
// Round-robin burst arbiter: shares one fixed-latency memory port between icache and dcache
// refills, issuing critical-word-first wrapping bursts and routing returned beats to the owner.
module riscv_mem_arbiter #(
    parameter int BURST_LEN    = 4,
    parameter int BEAT_BYTES   = 8,
    parameter int READ_LATENCY = 2
) (
    input logic                clk,
    input logic                srst_n,
    riscv_mem_arbiter_if.slave bus
);
    localparam int IDX_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int OFF_W  = $clog2(BEAT_BYTES);
    localparam int LINE_W = IDX_W + OFF_W;
    localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(BURST_LEN - 1);
    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WRITE = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t                  state_r, state_s;
    logic [IDX_W-1:0]        beat_cnt_r;
    logic                    last_owner_r;
    logic [31:0]             addr_r;
    logic [31:0]             wdata_r;
    logic [3:0]              wen_r;
    logic [READ_LATENCY-1:0] pipe_vld_r, pipe_own_r, pipe_last_r, pipe_a2_r;

    logic             gnt_i_s, gnt_d_s;
    logic             issue_s, write_s, beat_last_s, pipe_busy_s, entry_a2_s;
    logic             ret_vld_s, ret_own_s, ret_last_s, ret_a2_s;
    logic [IDX_W-1:0] beat_idx_s;
    logic [31:0]      beat_addr_s;

    assign issue_s     = (state_r == ST_ISSUE);
    assign write_s     = (state_r == ST_WRITE);
    assign beat_last_s = (beat_cnt_r == LAST_BEAT);
    assign beat_idx_s  = addr_r[LINE_W-1:OFF_W] + beat_cnt_r;
    assign beat_addr_s = {addr_r[31:LINE_W], beat_idx_s, {OFF_W{1'b0}}};
    // The critical word keeps its half-word select; later beats start on a 64-bit boundary.
    assign entry_a2_s  = (beat_cnt_r == {IDX_W{1'b0}}) ? addr_r[2] : 1'b0;

    assign ret_vld_s  = srst_n & pipe_vld_r[READ_LATENCY-1];
    assign ret_own_s  = pipe_own_r[READ_LATENCY-1];
    assign ret_last_s = pipe_last_r[READ_LATENCY-1];
    assign ret_a2_s   = pipe_a2_r[READ_LATENCY-1];

    // Beats still in flight other than the one leaving the pipeline this cycle.
    always_comb begin
        pipe_busy_s = 1'b0;
        for (int s = 0; s < READ_LATENCY - 1; s++) begin
            pipe_busy_s = pipe_busy_s | pipe_vld_r[s];
        end
    end

    // Next-state and round-robin grant decision.
    always_comb begin
        state_s = state_r;
        gnt_i_s = 1'b0;
        gnt_d_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.i_req && bus.d_req) begin
                    gnt_i_s = (last_owner_r == OWN_D);
                    gnt_d_s = (last_owner_r == OWN_I);
                end else begin
                    gnt_i_s = bus.i_req;
                    gnt_d_s = bus.d_req;
                end
                if (gnt_d_s && (bus.d_wen != 4'd0)) begin
                    state_s = ST_WRITE;
                end else if (gnt_i_s || gnt_d_s) begin
                    state_s = ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: state_s = beat_last_s ? ST_DRAIN : ST_ISSUE;
            ST_WRITE: state_s = ST_IDLE;
            ST_DRAIN: state_s = pipe_busy_s ? ST_DRAIN : ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // State, request capture, beat counter and read-latency pipeline.
    always_ff @(posedge clk) begin
        if (!srst_n) begin
            state_r      <= ST_IDLE;
            beat_cnt_r   <= {IDX_W{1'b0}};
            last_owner_r <= OWN_D;
            addr_r       <= 32'd0;
            wdata_r      <= 32'd0;
            wen_r        <= 4'd0;
            pipe_vld_r   <= {READ_LATENCY{1'b0}};
            pipe_own_r   <= {READ_LATENCY{1'b0}};
            pipe_last_r  <= {READ_LATENCY{1'b0}};
            pipe_a2_r    <= {READ_LATENCY{1'b0}};
        end else begin
            state_r <= state_s;
            if (gnt_i_s) begin
                addr_r       <= bus.i_addr;
                wdata_r      <= 32'd0;
                wen_r        <= 4'd0;
                last_owner_r <= OWN_I;
            end else if (gnt_d_s) begin
                addr_r       <= bus.d_addr;
                wdata_r      <= bus.d_wdata;
                wen_r        <= bus.d_wen;
                last_owner_r <= OWN_D;
            end
            if (issue_s && !beat_last_s) begin
                beat_cnt_r <= beat_cnt_r + {{(IDX_W-1){1'b0}}, 1'b1};
            end else begin
                beat_cnt_r <= {IDX_W{1'b0}};
            end
            for (int s = READ_LATENCY - 1; s > 0; s--) begin
                pipe_vld_r[s]  <= pipe_vld_r[s-1];
                pipe_own_r[s]  <= pipe_own_r[s-1];
                pipe_last_r[s] <= pipe_last_r[s-1];
                pipe_a2_r[s]   <= pipe_a2_r[s-1];
            end
            pipe_vld_r[0]  <= issue_s;
            pipe_own_r[0]  <= issue_s & last_owner_r;
            pipe_last_r[0] <= issue_s & beat_last_s;
            pipe_a2_r[0]   <= issue_s & entry_a2_s;
        end
    end

    // Output drive; everything is held at zero while reset is asserted.
    always_comb begin
        bus.i_gnt     = srst_n & gnt_i_s;
        bus.d_gnt     = srst_n & gnt_d_s;
        bus.busy      = srst_n & (state_r != ST_IDLE);
        bus.mem_ren   = 1'b0;
        bus.mem_addr  = 32'd0;
        bus.mem_wen   = 4'd0;
        bus.mem_wdata = 32'd0;
        if (srst_n && issue_s) begin
            bus.mem_ren  = 1'b1;
            bus.mem_addr = beat_addr_s;
        end else if (srst_n && write_s) begin
            bus.mem_addr  = addr_r;
            bus.mem_wen   = wen_r;
            bus.mem_wdata = wdata_r;
        end else begin
            bus.mem_ren = 1'b0;
        end
        bus.i_rvalid = ret_vld_s & (ret_own_s == OWN_I);
        bus.i_rlast  = bus.i_rvalid & ret_last_s;
        bus.i_rdata  = bus.i_rvalid ? bus.mem_rdata : 64'd0;
        bus.d_rvalid = ret_vld_s & (ret_own_s == OWN_D);
        bus.d_rlast  = bus.d_rvalid & ret_last_s;
        bus.d_rdata  = !bus.d_rvalid ? 32'd0 :
                       (ret_a2_s ? bus.mem_rdata[63:32] : bus.mem_rdata[31:0]);
    end
endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Randomised + directed bench for riscv_mem_arbiter against a transaction-level schedule model.
module tb_riscv_mem_arbiter;
    localparam int BL  = 4;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic srst_n;
    riscv_mem_arbiter_if bus_if();

    riscv_mem_arbiter #(.BURST_LEN(BL), .BEAT_BYTES(8), .READ_LATENCY(LAT)) dut (
        .clk(clk), .srst_n(srst_n), .bus(bus_if)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        ren;
        logic [31:0] addr;
        logic [3:0]  wen;
        logic [31:0] wdata;
        logic        iv;
        logic        il;
        logic [63:0] idata;
        logic        dv;
        logic        dl;
        logic [31:0] ddata;
    } exp_t;

    exp_t        sched [int];
    logic        hist_ren [int];
    logic [31:0] hist_addr [int];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int          free_at = 0;
    logic        last_owner = 1'b1;
    bit          const_mode = 1'b0;
    logic [31:0] t2_addr [4] = '{32'h18, 32'h00, 32'h08, 32'h10};

    function automatic logic [63:0] memf(input logic [31:0] a);
        return const_mode ? 64'h1111_2222_3333_4444 : {~a, a};
    endfunction

    function automatic exp_t slot(input int c);
        if (sched.exists(c)) return sched[c];
        return '0;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d act=%0h exp=%0h", name, cyc, act, exp);
        end
    endtask

    // Schedule a wrapping critical-word-first burst granted in the current cycle.
    task automatic plan_read(input logic own, input logic [31:0] a);
        exp_t        e;
        logic [31:0] ba;
        logic [63:0] w;
        int          idx;
        for (int k = 0; k < BL; k++) begin
            idx = (int'(a[31:3]) + k) % BL;
            ba  = (a / 32'(BL * 8)) * 32'(BL * 8) + 32'(idx * 8);
            e = slot(cyc + 1 + k);
            e.ren = 1'b1; e.addr = ba;
            sched[cyc + 1 + k] = e;
            w = memf(ba);
            e = slot(cyc + 1 + k + LAT);
            if (own == 1'b0) begin
                e.iv = 1'b1; e.il = (k == BL - 1); e.idata = w;
            end else begin
                e.dv = 1'b1; e.dl = (k == BL - 1);
                e.ddata = ((k == 0) && a[2]) ? w[63:32] : w[31:0];
            end
            sched[cyc + 1 + k + LAT] = e;
        end
        free_at = cyc + BL + LAT + 1;
    endtask

    // Memory: returns data for the address strobed LAT cycles earlier, garbage otherwise.
    initial begin
        bus_if.mem_rdata = 64'd0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (hist_ren.exists(cyc - LAT) && hist_ren[cyc - LAT] === 1'b1)
                bus_if.mem_rdata = memf(hist_addr[cyc - LAT]);
            else
                bus_if.mem_rdata = {$urandom, $urandom};
        end
    end

    // Reference model and per-cycle comparison.
    initial begin
        exp_t e;
        logic gi, gd, bz;
        forever begin
            @(negedge clk);
            e = '0; gi = 1'b0; gd = 1'b0; bz = 1'b0;
            if (srst_n !== 1'b1) begin
                sched.delete();
                free_at = cyc + 1;
                last_owner = 1'b1;
            end else begin
                e  = slot(cyc);
                bz = (cyc < free_at);
                if (!bz) begin
                    if (bus_if.i_req && bus_if.d_req) begin
                        gi = last_owner; gd = !last_owner;
                    end else begin
                        gi = bus_if.i_req; gd = bus_if.d_req;
                    end
                end
            end
            chk("i_gnt",     64'(bus_if.i_gnt),     64'(gi));
            chk("d_gnt",     64'(bus_if.d_gnt),     64'(gd));
            chk("busy",      64'(bus_if.busy),      64'(bz));
            chk("mem_ren",   64'(bus_if.mem_ren),   64'(e.ren));
            chk("mem_addr",  64'(bus_if.mem_addr),  64'(e.addr));
            chk("mem_wen",   64'(bus_if.mem_wen),   64'(e.wen));
            chk("mem_wdata", 64'(bus_if.mem_wdata), 64'(e.wdata));
            chk("i_rvalid",  64'(bus_if.i_rvalid),  64'(e.iv));
            chk("i_rlast",   64'(bus_if.i_rlast),   64'(e.il));
            chk("i_rdata",   bus_if.i_rdata,        e.idata);
            chk("d_rvalid",  64'(bus_if.d_rvalid),  64'(e.dv));
            chk("d_rlast",   64'(bus_if.d_rlast),   64'(e.dl));
            chk("d_rdata",   64'(bus_if.d_rdata),   64'(e.ddata));
            if (gi) begin
                last_owner = 1'b0;
                plan_read(1'b0, bus_if.i_addr);
            end else if (gd) begin
                last_owner = 1'b1;
                if (bus_if.d_wen != 4'd0) begin
                    e = slot(cyc + 1);
                    e.addr = bus_if.d_addr; e.wen = bus_if.d_wen; e.wdata = bus_if.d_wdata;
                    sched[cyc + 1] = e;
                    free_at = cyc + 2;
                end else begin
                    plan_read(1'b1, bus_if.d_addr);
                end
            end
            sched.delete(cyc);
            hist_ren[cyc]  = bus_if.mem_ren;
            hist_addr[cyc] = bus_if.mem_addr;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (bus_if.busy !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("idle_wait", 64'(bus_if.busy), 64'd0);
    endtask

    // Directed scenarios followed by a randomised soak.
    initial begin
        logic gi, gd, who, prev;
        int   n_g;
        srst_n = 1'b0;
        bus_if.i_req = 1'b1; bus_if.i_addr = 32'h40;
        bus_if.d_req = 1'b1; bus_if.d_addr = 32'h80;
        bus_if.d_wen = 4'd0; bus_if.d_wdata = 32'd0;

        repeat (3) begin
            @(negedge clk);
            chk("t1_rst_gnt", 64'({bus_if.i_gnt, bus_if.d_gnt}), 64'd0);
            chk("t1_rst_ren", 64'(bus_if.mem_ren), 64'd0);
        end
        tick(); srst_n = 1'b1;
        @(negedge clk);
        chk("t1_i_gnt", 64'(bus_if.i_gnt), 64'd1);
        chk("t1_d_gnt", 64'(bus_if.d_gnt), 64'd0);
        tick(); bus_if.i_req = 1'b0; bus_if.d_req = 1'b0;

        wait_idle();
        tick(); bus_if.i_addr = 32'h18; bus_if.i_req = 1'b1;
        @(negedge clk);
        chk("t2_gnt", 64'(bus_if.i_gnt), 64'd1);
        tick(); bus_if.i_req = 1'b0;
        for (int t = 1; t <= 7; t++) begin
            @(negedge clk);
            if (t <= 4) chk("t2_addr", 64'(bus_if.mem_addr), 64'(t2_addr[t-1]));
            if (t >= 3 && t <= 6) begin
                chk("t2_rvalid", 64'(bus_if.i_rvalid), 64'd1);
                chk("t2_rlast", 64'(bus_if.i_rlast), 64'(t == 6));
            end
            if (t == 3) chk("t2_rdata", bus_if.i_rdata, 64'hFFFF_FFE7_0000_0018);
            if (t == 7) chk("t2_busy", 64'(bus_if.busy), 64'd0);
        end

        wait_idle();
        tick();
        bus_if.i_req = 1'b1; bus_if.d_req = 1'b1; bus_if.d_wen = 4'd0;
        bus_if.i_addr = $urandom; bus_if.d_addr = $urandom;
        n_g = 0; prev = 1'b0;
        for (int n = 0; n < 100 && n_g < 4; n++) begin
            @(negedge clk);
            gi = bus_if.i_gnt; gd = bus_if.d_gnt;
            if (gi || gd) begin
                who = gd;
                if (n_g == 0) chk("t3_first", 64'(who), 64'd1);
                else chk("t3_alt", 64'(who), 64'(!prev));
                prev = who;
                n_g++;
            end
            tick();
            if (gi) bus_if.i_addr = $urandom;
            if (gd) bus_if.d_addr = $urandom;
        end
        chk("t3_count", 64'(n_g), 64'd4);
        bus_if.i_req = 1'b0; bus_if.d_req = 1'b0;

        wait_idle();
        tick();
        const_mode = 1'b1;
        bus_if.d_req = 1'b1; bus_if.d_wen = 4'b0011;
        bus_if.d_addr = 32'h1000_0004; bus_if.d_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("t4_gnt", 64'(bus_if.d_gnt), 64'd1);
        tick(); bus_if.d_wen = 4'd0; bus_if.d_wdata = 32'd0;
        @(negedge clk);
        chk("t4_wen", 64'(bus_if.mem_wen), 64'h3);
        chk("t4_addr", 64'(bus_if.mem_addr), 64'h1000_0004);
        chk("t4_wdata", 64'(bus_if.mem_wdata), 64'hDEAD_BEEF);
        chk("t4_ren", 64'(bus_if.mem_ren), 64'd0);
        chk("t4_no_rvalid", 64'(bus_if.d_rvalid), 64'd0);
        tick();
        @(negedge clk);
        chk("t5_gnt", 64'(bus_if.d_gnt), 64'd1);
        tick(); bus_if.d_req = 1'b0;
        for (int t = 1; t <= 4; t++) begin
            @(negedge clk);
            if (t == 1) chk("t5_addr0", 64'(bus_if.mem_addr), 64'h1000_0000);
            if (t == 3) begin
                chk("t5_rvalid0", 64'(bus_if.d_rvalid), 64'd1);
                chk("t5_rdata0", 64'(bus_if.d_rdata), 64'h1111_2222);
            end
            if (t == 4) chk("t5_rdata1", 64'(bus_if.d_rdata), 64'h3333_4444);
        end
        wait_idle();
        tick(); const_mode = 1'b0;

        bus_if.i_addr = 32'h0000_2000; bus_if.i_req = 1'b1;
        @(negedge clk);
        chk("t6_gnt", 64'(bus_if.i_gnt), 64'd1);
        tick(); bus_if.i_req = 1'b0;
        tick();
        tick(); srst_n = 1'b0;
        tick(); srst_n = 1'b1;
        for (int t = 4; t <= 6; t++) begin
            @(negedge clk);
            chk("t6_rvalid", 64'(bus_if.i_rvalid), 64'd0);
            chk("t6_busy", 64'(bus_if.busy), 64'd0);
            chk("t6_ren", 64'(bus_if.mem_ren), 64'd0);
            tick();
        end
        bus_if.i_req = 1'b1;
        @(negedge clk);
        chk("t6_regnt", 64'(bus_if.i_gnt), 64'd1);
        tick(); bus_if.i_req = 1'b0;

        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            gi = bus_if.i_gnt; gd = bus_if.d_gnt;
            tick();
            srst_n = ($urandom_range(0, 399) != 0);
            if (gi || !bus_if.i_req) begin
                bus_if.i_req = ($urandom_range(0, 3) == 0);
                bus_if.i_addr = $urandom;
            end else if ($urandom_range(0, 15) == 0) begin
                bus_if.i_req = 1'b0;
            end
            if (gd || !bus_if.d_req) begin
                bus_if.d_req = ($urandom_range(0, 3) == 0);
                bus_if.d_addr = $urandom;
                bus_if.d_wdata = $urandom;
                bus_if.d_wen = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            end else if ($urandom_range(0, 15) == 0) begin
                bus_if.d_req = 1'b0;
            end
        end
        bus_if.i_req = 1'b0; bus_if.d_req = 1'b0; srst_n = 1'b1;
        repeat (12) @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
